// File: rtl/ysyx_25040101_ifu.sv
// ----------------------------------------------------------------------------
// ysyx_25040101_ifu
// Instruction fetch unit for the nebula-core-B RV32 core. It holds the
// architectural PC and fetches one word at a time. The word goes downstream
// over a valid/ready handshake, and the unit waits for the retired next PC
// before it fetches again. Only one instruction is ever in flight.
//
// Ports
//   clk_i          core clock, rising-edge
//   rst_i          asynchronous active-high reset
//   imem_req_o     one-cycle fetch request strobe
//   imem_addr_o    fetch address (always the current PC)
//   imem_rvalid_i  memory response valid
//   imem_rdata_i   instruction word returned by memory
//   imem_err_i     bus error, qualified by imem_rvalid_i
//   inst_o         latched instruction word
//   inst_valid_o   inst_o holds an unconsumed instruction
//   inst_ready_i   downstream accepts inst_o
//   pc_o           PC of the instruction being fetched or executed
//   dnpc_i         next PC from the execute stage
//   dnpc_valid_i   strobe: current instruction retired, dnpc_i is final
//   fetch_err_o    sticky fault (bus error or misaligned PC)
//   inst_cnt_o     number of instructions handed downstream (wraps)
// ----------------------------------------------------------------------------
module ysyx_25040101_ifu #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        imem_err_i,
  output logic [31:0] inst_o,
  output logic        inst_valid_o,
  input  logic        inst_ready_i,
  output logic [31:0] pc_o,
  input  logic [31:0] dnpc_i,
  input  logic        dnpc_valid_i,
  output logic        fetch_err_o,
  output logic [31:0] inst_cnt_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_WAIT  = 3'd2,
    S_VALID = 3'd3,
    S_EXEC  = 3'd4,
    S_ERR   = 3'd5
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] cnt_q, cnt_d;
  logic        req_q;
  logic        valid_q;
  logic        err_q;

  // Next-state and datapath update rules of the fetch FSM.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (RESET_PC[1:0] != 2'b00) begin
          state_d = S_ERR;
        end else begin
          state_d = S_FETCH;
        end
      end
      // Any response arriving while the request is still being issued is stale.
      S_FETCH: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_rvalid_i) begin
          // Error takes priority; inst_o keeps its previous contents.
          if (imem_err_i) begin
            state_d = S_ERR;
          end else begin
            state_d = S_VALID;
            inst_d  = imem_rdata_i;
          end
        end else begin
          state_d = S_WAIT;
        end
      end
      S_VALID: begin
        if (inst_ready_i) begin
          state_d = S_EXEC;
          cnt_d   = cnt_q + 32'd1;
        end else begin
          state_d = S_VALID;
        end
      end
      S_EXEC: begin
        if (dnpc_valid_i) begin
          // The faulting target is still recorded so software can inspect it.
          pc_d = dnpc_i;
          if (dnpc_i[1:0] != 2'b00) begin
            state_d = S_ERR;
          end else begin
            state_d = S_FETCH;
          end
        end else begin
          state_d = S_EXEC;
        end
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_ERR;
      end
    endcase
  end

  // State, datapath registers and outputs registered from the next state.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      inst_q  <= 32'd0;
      cnt_q   <= 32'd0;
      req_q   <= 1'b0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
      cnt_q   <= cnt_d;
      req_q   <= (state_d == S_FETCH);
      valid_q <= (state_d == S_VALID);
      err_q   <= (state_d == S_ERR);
    end
  end

  assign imem_req_o   = req_q;
  assign imem_addr_o  = pc_q;
  assign pc_o         = pc_q;
  assign inst_o       = inst_q;
  assign inst_valid_o = valid_q;
  assign fetch_err_o  = err_q;
  assign inst_cnt_o   = cnt_q;

endmodule

// File: tb/tb_ysyx_25040101_ifu.sv
module tb_ysyx_25040101_ifu;

  localparam logic [31:0] RST_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = 32'd0;
  logic        imem_err_i = 1'b0;
  logic [31:0] inst_o;
  logic        inst_valid_o;
  logic        inst_ready_i = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] dnpc_i = 32'd0;
  logic        dnpc_valid_i = 1'b0;
  logic        fetch_err_o;
  logic [31:0] inst_cnt_o;

  ysyx_25040101_ifu #(.RESET_PC(RST_PC)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i), .imem_err_i(imem_err_i),
    .inst_o(inst_o), .inst_valid_o(inst_valid_o), .inst_ready_i(inst_ready_i),
    .pc_o(pc_o), .dnpc_i(dnpc_i), .dnpc_valid_i(dnpc_valid_i),
    .fetch_err_o(fetch_err_o), .inst_cnt_o(inst_cnt_o)
  );

  always #5 clk = ~clk;

  // Reference model: architectural view of the fetch unit.
  logic [31:0] exp_pc   = RST_PC;
  logic [31:0] exp_inst = 32'd0;
  logic [31:0] exp_cnt  = 32'd0;
  logic        exp_err  = 1'b0;
  int          exp_reqs = 0;
  int          req_seen = 0;
  int          n_cmp = 0;
  int          n_bad = 0;

  // Count request pulses on the falling edge, away from the update edge.
  always @(negedge clk) if (imem_req_o === 1'b1) req_seen++;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_pc", pc_o, RST_PC);
    chk("rst_addr", imem_addr_o, RST_PC);
    chk("rst_inst", inst_o, 32'd0);
    chk("rst_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("rst_req", {31'd0, imem_req_o}, 32'd0);
    chk("rst_err", {31'd0, fetch_err_o}, 32'd0);
    chk("rst_cnt", inst_cnt_o, 32'd0);
  endtask

  // Assert reset between edges and check it takes effect without a clock.
  task automatic async_reset();
    #2;
    rst_i = 1'b1;
    #1;
    chk_reset_vals();
    exp_pc = RST_PC; exp_inst = 32'd0; exp_cnt = 32'd0; exp_err = 1'b0;
    step();
    rst_i = 1'b0;
    step();
  endtask

  // Serve one fetch: find the request, respond after k cycles.
  task automatic do_fetch(input int k, input logic [31:0] data, input bit berr,
                          input bit stray_rv, input bit stray_dn);
    int t = 0;
    while (imem_req_o !== 1'b1 && t < 20) begin step(); t++; end
    chk("req_seen", {31'd0, imem_req_o}, 32'd1);
    chk("fetch_addr", imem_addr_o, exp_pc);
    exp_reqs++;
    if (stray_rv) begin
      imem_rvalid_i = 1'b1; imem_rdata_i = $urandom; imem_err_i = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < k; i++) begin
      step();
      imem_rvalid_i = 1'b0; imem_err_i = 1'b0; dnpc_valid_i = 1'b0;
      chk("wait_noreq", {31'd0, imem_req_o}, 32'd0);
      chk("wait_novalid", {31'd0, inst_valid_o}, 32'd0);
      chk("wait_pc", pc_o, exp_pc);
      if (stray_dn && i == 0) begin dnpc_valid_i = 1'b1; dnpc_i = $urandom; end
    end
    imem_rvalid_i = 1'b1; imem_rdata_i = data; imem_err_i = berr;
    step();
    imem_rvalid_i = 1'b0; imem_err_i = 1'b0; dnpc_valid_i = 1'b0;
    if (berr) exp_err = 1'b1; else exp_inst = data;
    chk("resp_valid", {31'd0, inst_valid_o}, {31'd0, ~berr});
    chk("resp_inst", inst_o, exp_inst);
    chk("resp_err", {31'd0, fetch_err_o}, {31'd0, exp_err});
    chk("resp_pc", pc_o, exp_pc);
  endtask

  // Hold ready low for 'hold' cycles, then accept with ready held two cycles.
  task automatic do_accept(input int hold, input bit stray_dn);
    for (int i = 0; i < hold; i++) begin
      if (stray_dn && i == 0) begin dnpc_valid_i = 1'b1; dnpc_i = $urandom; end
      step();
      dnpc_valid_i = 1'b0;
      chk("bp_valid", {31'd0, inst_valid_o}, 32'd1);
      chk("bp_inst", inst_o, exp_inst);
      chk("bp_pc", pc_o, exp_pc);
      chk("bp_cnt", inst_cnt_o, exp_cnt);
      chk("bp_noreq", req_seen, exp_reqs);
    end
    inst_ready_i = 1'b1;
    step();
    exp_cnt = exp_cnt + 32'd1;
    chk("acc_valid", {31'd0, inst_valid_o}, 32'd0);
    chk("acc_cnt", inst_cnt_o, exp_cnt);
    step();
    inst_ready_i = 1'b0;
    chk("acc_once", inst_cnt_o, exp_cnt);
    chk("acc_noreq", {31'd0, imem_req_o}, 32'd0);
  endtask

  // Retire the current instruction with next PC npc.
  task automatic do_retire(input logic [31:0] npc);
    dnpc_i = npc; dnpc_valid_i = 1'b1;
    step();
    dnpc_valid_i = 1'b0;
    exp_pc = npc;
    if (npc[1:0] != 2'b00) exp_err = 1'b1;
    chk("ret_pc", pc_o, exp_pc);
    chk("ret_err", {31'd0, fetch_err_o}, {31'd0, exp_err});
    chk("ret_req", {31'd0, imem_req_o}, {31'd0, ~exp_err});
    chk("ret_addr", imem_addr_o, exp_pc);
  endtask

  initial begin
    logic [31:0] tgt;
    step(); step();
    chk_reset_vals();
    rst_i = 1'b0;
    step();
    // First request must already be up in cycle 1.
    chk("first_req", {31'd0, imem_req_o}, 32'd1);
    do_fetch(1, 32'h0000_0413, 1'b0, 1'b0, 1'b0);
    do_accept(0, 1'b0);

    // Backpressure with stray strobes.
    do_retire(exp_pc + 32'd4);
    do_fetch(int'($urandom_range(1, 4)), $urandom, 1'b0, 1'b1, 1'b1);
    do_accept(10, 1'b1);

    // Sequential loop with k = 3.
    for (int i = 0; i < 3; i++) begin
      do_retire(exp_pc + 32'd4);
      do_fetch(3, $urandom, 1'b0, 1'b0, 1'b0);
      do_accept(int'($urandom_range(0, 3)), 1'b0);
    end
    chk("seq_pc", pc_o, RST_PC + 32'd16);

    // Random aligned branch targets and latencies.
    for (int i = 0; i < 5; i++) begin
      tgt = $urandom;
      tgt[1:0] = 2'b00;
      do_retire(tgt);
      do_fetch(int'($urandom_range(1, 5)), $urandom, 1'b0,
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      do_accept(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end
    chk("req_total", req_seen, exp_reqs);

    // Misaligned jump target, then stray strobes that must be ignored.
    do_retire(32'h8000_0102);
    for (int i = 0; i < 6; i++) begin
      dnpc_valid_i = 1'b1; dnpc_i = $urandom; imem_rvalid_i = 1'b1; imem_rdata_i = $urandom;
      inst_ready_i = 1'b1;
      step();
      chk("err_pc", pc_o, 32'h8000_0102);
      chk("err_sticky", {31'd0, fetch_err_o}, 32'd1);
      chk("err_novalid", {31'd0, inst_valid_o}, 32'd0);
    end
    dnpc_valid_i = 1'b0; imem_rvalid_i = 1'b0; inst_ready_i = 1'b0;
    chk("err_noreq", req_seen, exp_reqs);
    chk("err_cnt", inst_cnt_o, exp_cnt);

    // Reset out of ERR, then a bus error after a good fetch.
    async_reset();
    do_fetch(2, 32'hdead_beef, 1'b0, 1'b0, 1'b0);
    do_accept(1, 1'b0);
    do_retire(exp_pc + 32'd4);
    do_fetch(int'($urandom_range(1, 3)), 32'h1234_5678, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("berr_inst", inst_o, 32'hdead_beef);
      chk("berr_sticky", {31'd0, fetch_err_o}, 32'd1);
    end
    chk("berr_noreq", req_seen, exp_reqs);

    // Reset clears ERR; then reset again in the middle of a WAIT.
    async_reset();
    chk("restart_req", {31'd0, imem_req_o}, 32'd1);
    chk("restart_addr", imem_addr_o, RST_PC);
    exp_reqs++;
    step();
    async_reset();
    do_fetch(2, 32'h0050_0093, 1'b0, 1'b0, 1'b0);
    do_accept(0, 1'b0);
    chk("final_cnt", inst_cnt_o, 32'd1);
    step();
    chk("final_reqs", req_seen, exp_reqs);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
